// File: rtl/fx_fp_pkg.sv
// Shared constants and FSM encoding for the fixed-to-float converter.
// Holds exponent bias, field widths and the converter state type.
package fx_fp_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;
    localparam int FX_W     = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS,
        S_NORM,
        S_PACK,
        S_DONE
    } state_e;

endpackage

// File: rtl/fx_norm_shifter.sv
// Normalising shift register: loads a magnitude, shifts it left one bit
// per enabled cycle and counts shifts in lz.
// Ports: clk_i, rst_i (sync, active-high), load_i + mag_i (load and
// clear lz), shift_i (shift/count), mag_o, msb_o, lz_o.
module fx_norm_shifter
    import fx_fp_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic [FX_W-1:0] mag_i,
    input  logic            shift_i,
    output logic [FX_W-1:0] mag_o,
    output logic            msb_o,
    output logic [4:0]      lz_o
);

    logic [FX_W-1:0] mag_q, mag_d;
    logic [4:0]      lz_q, lz_d;

    always_comb begin
        mag_d = mag_q;
        lz_d  = lz_q;
        if (load_i) begin
            mag_d = mag_i;
            lz_d  = 5'd0;
        end else if (shift_i) begin
            mag_d = {mag_q[FX_W-2:0], 1'b0};
            lz_d  = lz_q + 5'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mag_q <= '0;
            lz_q  <= '0;
        end else begin
            mag_q <= mag_d;
            lz_q  <= lz_d;
        end
    end

    assign mag_o = mag_q;
    assign msb_o = mag_q[FX_W-1];
    assign lz_o  = lz_q;

endmodule

// File: rtl/fixed_to_float_converter.sv
// Multi-cycle two's-complement fixed-point to IEEE-754 single converter.
// Ports: CLK, RST_FF (sync reset), Begin_FSM_FX (start), RST_FSM_FX
// (acknowledge), FIXED (operand), FLOAT (result), BUSY, ACK_FX.
// Build option: FX2FP_ROUND_NEAREST_EN enables round-to-nearest-even,
// otherwise the mantissa is truncated.
module fixed_to_float_converter
    import fx_fp_pkg::*;
#(
    parameter int FRAC_W = 23
) (
    input  logic            CLK,
    input  logic            RST_FF,
    input  logic            Begin_FSM_FX,
    input  logic            RST_FSM_FX,
    input  logic [FX_W-1:0] FIXED,
    output logic [FX_W-1:0] FLOAT,
    output logic            BUSY,
    output logic            ACK_FX
);

    state_e          state_q;
    logic [FX_W-1:0] operand_q;
    logic            sign_q;
    logic            zero_q;
    logic [FX_W-1:0] float_q;
    logic            ack_q;
    logic            busy_q;

    logic [FX_W-1:0] abs_val;
    logic [FX_W-1:0] mag;
    logic            msb;
    logic [4:0]      lz;
    logic            load;
    logic            shift;
    logic [8:0]      exp_d;
    logic [MANT_W-1:0] mant_d;
    logic [FX_W-1:0] float_d;

    // Negating 0x80000000 wraps to itself, which is the correct magnitude.
    assign abs_val = operand_q[FX_W-1] ? (~operand_q + 32'd1) : operand_q;
    assign load    = (state_q == S_ABS);
    assign shift   = (state_q == S_NORM) && !msb && !zero_q;

    fx_norm_shifter u_shift (
        .clk_i   (CLK),
        .rst_i   (RST_FF),
        .load_i  (load),
        .mag_i   (abs_val),
        .shift_i (shift),
        .mag_o   (mag),
        .msb_o   (msb),
        .lz_o    (lz)
    );

`ifdef FX2FP_ROUND_NEAREST_EN
    logic            guard;
    logic            sticky;
    logic            rnd;
    logic [MANT_W:0] mant_r;
    logic            unused_bits;

    assign unused_bits = mag[FX_W-1];

    always_comb begin
        exp_d  = 9'(EXP_BIAS + FX_W - 1 - FRAC_W) - 9'(lz);
        guard  = mag[7];
        sticky = |mag[6:0];
        rnd    = guard & (sticky | mag[8]);
        mant_r = {1'b0, mag[FX_W-2:8]} + (MANT_W+1)'(rnd);
        mant_d = mant_r[MANT_W-1:0];
        // Carry out of the mantissa: value becomes the next power of two.
        if (mant_r[MANT_W]) begin
            mant_d = '0;
            exp_d  = exp_d + 9'd1;
        end
    end
`else
    logic unused_bits;

    assign unused_bits = ^{mag[FX_W-1], mag[7:0]};

    always_comb begin
        exp_d  = 9'(EXP_BIAS + FX_W - 1 - FRAC_W) - 9'(lz);
        mant_d = mag[FX_W-2:8];
    end
`endif

    // Zero forces +0.0 regardless of the computed fields.
    assign float_d = zero_q ? '0 : {sign_q, exp_d[EXP_W-1:0], mant_d};

    always_ff @(posedge CLK) begin
        if (RST_FF) begin
            state_q   <= S_IDLE;
            operand_q <= '0;
            sign_q    <= 1'b0;
            zero_q    <= 1'b0;
            float_q   <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (Begin_FSM_FX) begin
                        operand_q <= FIXED;
                        state_q   <= S_ABS;
                        busy_q    <= 1'b1;
                    end
                end
                S_ABS: begin
                    sign_q  <= operand_q[FX_W-1];
                    zero_q  <= (abs_val == '0);
                    state_q <= S_NORM;
                end
                S_NORM: begin
                    if (msb || zero_q) begin
                        state_q <= S_PACK;
                    end
                end
                S_PACK: begin
                    float_q <= float_d;
                    ack_q   <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    if (RST_FSM_FX) begin
                        ack_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign FLOAT  = float_q;
    assign ACK_FX = ack_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_fixed_to_float_converter.sv
// Self-checking bench for fixed_to_float_converter (FRAC_W=23).
// Directed table, random vectors against a value-level model, and sequences.
module tb_fixed_to_float_converter;

    localparam int FRAC_W = 23;

    logic        CLK;
    logic        RST_FF;
    logic        Begin_FSM_FX;
    logic        RST_FSM_FX;
    logic [31:0] FIXED;
    logic [31:0] FLOAT;
    logic        BUSY;
    logic        ACK_FX;

    int errors = 0;
    int checks = 0;

    fixed_to_float_converter #(.FRAC_W(FRAC_W)) dut (
        .CLK          (CLK),
        .RST_FF       (RST_FF),
        .Begin_FSM_FX (Begin_FSM_FX),
        .RST_FSM_FX   (RST_FSM_FX),
        .FIXED        (FIXED),
        .FLOAT        (FLOAT),
        .BUSY         (BUSY),
        .ACK_FX       (ACK_FX)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] fx;
        logic [31:0] fl;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Value-level reference: locate the leading one, scale by 2^-FRAC_W,
    // keep 24 significant bits, optionally rounding to nearest-even.
    function automatic void model(input logic [31:0] fx,
                                  output logic [31:0] fl,
                                  output int lat);
        longint mag, sig, rem, half;
        int p, e;
        mag = fx[31] ? longint'((~fx + 32'd1)) : longint'(fx);
        if (fx == 32'h8000_0000) mag = 64'h8000_0000;
        if (mag == 0) begin
            fl  = 32'h0;
            lat = 3;
            return;
        end
        p = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) p = i;
        lat = 3 + 31 - p;
        e = 127 + p - FRAC_W;
        if (p >= 23) begin
            sig = mag >> (p - 23);
`ifdef FX2FP_ROUND_NEAREST_EN
            if (p > 23) begin
                rem  = mag & ((64'd1 << (p - 23)) - 1);
                half = 64'd1 << (p - 24);
                if (rem > half || (rem == half && sig[0])) sig = sig + 1;
                if (sig == (64'd1 << 24)) begin
                    sig = sig >> 1;
                    e   = e + 1;
                end
            end
`else
            rem  = 0;
            half = 0;
`endif
        end else begin
            sig = mag << (23 - p);
        end
        fl = {fx[31], 8'(e), 23'(sig)};
    endfunction

    task automatic ack_result();
        RST_FSM_FX = 1'b1;
        @(posedge CLK); #1;
        RST_FSM_FX = 1'b0;
        chk("ack_clear", {31'b0, ACK_FX}, 32'h0);
        chk("busy_clear", {31'b0, BUSY}, 32'h0);
    endtask

    // Called #1 after an edge; returns result and edge count to ACK_FX.
    task automatic convert(input logic [31:0] fx, output logic [31:0] fl,
                           output int lat);
        Begin_FSM_FX = 1'b1;
        FIXED = fx;
        @(posedge CLK); #1;
        Begin_FSM_FX = 1'b0;
        FIXED = $urandom;
        chk("busy_run", {31'b0, BUSY}, 32'h1);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge CLK); #1;
            if (ACK_FX) begin
                lat = i;
                break;
            end
        end
        fl = FLOAT;
        if (lat == 0) begin
            $display("FAIL timeout: no ACK_FX for %h", fx);
            RST_FF = 1'b1;
            @(posedge CLK); #1;
            RST_FF = 1'b0;
        end
    endtask

    vec_t        tbl[9];
    logic [31:0] got, expf;
    int          lat, expl;
    bit          ok;

    initial begin
        tbl[0] = '{32'h0080_0000, 32'h3F80_0000, 11};
        tbl[1] = '{32'hFFA0_0000, 32'hBF40_0000, 12};
        tbl[2] = '{32'h0000_0000, 32'h0000_0000, 3};
        tbl[3] = '{32'h8000_0000, 32'hC380_0000, 3};
`ifdef FX2FP_ROUND_NEAREST_EN
        tbl[4] = '{32'h7FFF_FFFF, 32'h4380_0000, 4};
`else
        tbl[4] = '{32'h7FFF_FFFF, 32'h437F_FFFF, 4};
`endif
        tbl[5] = '{32'h0000_0001, 32'h3400_0000, 34};
        tbl[6] = '{32'hFF80_0000, 32'hBF80_0000, 11};
        tbl[7] = '{32'h0140_0000, 32'h4020_0000, 10};
        tbl[8] = '{32'hFFFF_FFFF, 32'hB400_0000, 34};

        RST_FF = 1'b1;
        Begin_FSM_FX = 1'b0;
        RST_FSM_FX = 1'b0;
        FIXED = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        RST_FF = 1'b0;
        chk("rst_float", FLOAT, 32'h0);
        chk("rst_ack", {31'b0, ACK_FX}, 32'h0);
        chk("rst_busy", {31'b0, BUSY}, 32'h0);

        foreach (tbl[k]) begin
            convert(tbl[k].fx, got, lat);
            chk($sformatf("tbl%0d_float", k), got, tbl[k].fl);
            chk($sformatf("tbl%0d_lat", k), lat, tbl[k].lat);
            ack_result();
        end

        for (int k = 0; k < 40; k++) begin
            logic [31:0] v;
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = ~v + 32'd1;
            model(v, expf, expl);
            convert(v, got, lat);
            chk($sformatf("rnd_float_%h", v), got, expf);
            chk($sformatf("rnd_lat_%h", v), lat, expl);
            ack_result();
        end

        // Begin pulsed during NORM is ignored.
        Begin_FSM_FX = 1'b1;
        FIXED = 32'h0000_0001;
        @(posedge CLK); #1;
        Begin_FSM_FX = 1'b0;
        repeat (4) begin
            @(posedge CLK); #1;
        end
        Begin_FSM_FX = 1'b1;
        FIXED = 32'h0080_0000;
        @(posedge CLK); #1;
        Begin_FSM_FX = 1'b0;
        lat = 0;
        for (int i = 6; i <= 40; i++) begin
            @(posedge CLK); #1;
            if (ACK_FX) begin
                lat = i;
                break;
            end
        end
        chk("ign_lat", lat, 34);
        chk("ign_float", FLOAT, 32'h3400_0000);
        ok = 1'b1;
        repeat (5) begin
            @(posedge CLK); #1;
            if (!ACK_FX) ok = 1'b0;
        end
        chk("ack_hold", {31'b0, ok}, 32'h1);
        ack_result();

        // Begin and acknowledge together in DONE: back to IDLE only.
        convert(32'h0080_0000, got, lat);
        chk("both_pre", got, 32'h3F80_0000);
        Begin_FSM_FX = 1'b1;
        RST_FSM_FX = 1'b1;
        FIXED = 32'h0000_0001;
        @(posedge CLK); #1;
        Begin_FSM_FX = 1'b0;
        RST_FSM_FX = 1'b0;
        chk("both_ack", {31'b0, ACK_FX}, 32'h0);
        chk("both_busy", {31'b0, BUSY}, 32'h0);
        @(posedge CLK); #1;
        chk("both_norestart", {31'b0, BUSY}, 32'h0);
        chk("both_hold", FLOAT, 32'h3F80_0000);

        // Reset in the middle of normalisation.
        Begin_FSM_FX = 1'b1;
        FIXED = 32'h0000_0001;
        @(posedge CLK); #1;
        Begin_FSM_FX = 1'b0;
        repeat (5) begin
            @(posedge CLK); #1;
        end
        RST_FF = 1'b1;
        @(posedge CLK); #1;
        RST_FF = 1'b0;
        chk("mid_float", FLOAT, 32'h0);
        chk("mid_ack", {31'b0, ACK_FX}, 32'h0);
        chk("mid_busy", {31'b0, BUSY}, 32'h0);
        convert(32'h0080_0000, got, lat);
        chk("post_float", got, 32'h3F80_0000);
        chk("post_lat", lat, 11);
        ack_result();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fixed_to_float_converter.md
FIXED_TO_FLOAT_CONVERTER -- requirements
Module: fixed_to_float_converter

Interface
REQ-001 The block SHALL have parameter FRAC_W, default 23, giving the number of fractional bits of FIXED (legal range 0..31).
REQ-002 The block SHALL have port CLK, input, 1 bit: system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RST_FF, input, 1 bit: system reset; one clock, reset synchronous and active-high.
REQ-004 The block SHALL have port Begin_FSM_FX, input, 1 bit: start-conversion request.
REQ-005 The block SHALL have port RST_FSM_FX, input, 1 bit: result acknowledge; releases the block from DONE.
REQ-006 The block SHALL have port FIXED, input, 32 bits: two's-complement fixed-point operand with FRAC_W fractional bits.
REQ-007 The block SHALL have port FLOAT, output, 32 bits: IEEE-754 single-precision result as {sign, exp[7:0], mant[22:0]}.
REQ-008 The block SHALL have port BUSY, output, 1 bit: high in every state except IDLE.
REQ-009 The block SHALL have port ACK_FX, output, 1 bit: high exactly while in DONE; FLOAT is valid while it is high.

Function
REQ-010 FSM states SHALL be IDLE, ABS, NORM, PACK, DONE.
REQ-011 IDLE: Begin_FSM_FX=1 -> capture FIXED into the operand register, go to ABS; otherwise stay in IDLE.
REQ-012 ABS: register sign=FIXED[31], magnitude=|FIXED| as 32-bit unsigned (0x80000000 -> 0x80000000), zero flag=(magnitude==0), clear the shift counter, go to NORM.
REQ-013 NORM: while magnitude[31]==0 and zero flag==0 -> shift magnitude left 1 bit and increment the 5-bit counter lz; otherwise go to PACK.
REQ-014 PACK: register FLOAT -- sign=sign; exp=127+31-lz-FRAC_W; mant=magnitude[30:8]; go to DONE.
REQ-015 Zero operand SHALL produce FLOAT=0x00000000 (+0.0, sign forced 0).
REQ-016 Exponent arithmetic SHALL be at least 9 bits wide; for FRAC_W 0..31 it always lies in 96..158, so overflow, denormal, and infinity handling SHALL be absent.
REQ-017 Latency SHALL be: ACK_FX high at the (3+lz)th rising edge after the edge that samples Begin_FSM_FX, with lz=0 for zero operands; maximum 34 cycles.
REQ-018 DONE: ACK_FX=1; RST_FSM_FX=1 -> IDLE at the next edge; otherwise hold.
REQ-019 Begin_FSM_FX SHALL be ignored outside IDLE.
REQ-020 Begin_FSM_FX and RST_FSM_FX both high in DONE -> go to IDLE only; no new conversion starts.
REQ-021 FLOAT SHALL hold its last value until the next PACK or reset; FIXED is not required to be stable after capture.

Reset
REQ-022 RST_FF=1 at a rising edge SHALL force IDLE, FLOAT=0x00000000, ACK_FX=0, BUSY=0, and clear the operand, counter, and flags, including mid-conversion.
REQ-023 RST_FF SHALL take priority over Begin_FSM_FX and RST_FSM_FX.

Configuration
REQ-024 Macro FX2FP_ROUND_NEAREST_EN defined -> PACK SHALL round mant to nearest-even using guard=magnitude[7] and sticky=|magnitude[6:0]; a mantissa carry-out SHALL zero mant and increment exp; latency is unchanged.
REQ-025 Macro FX2FP_ROUND_NEAREST_EN undefined -> PACK SHALL truncate (round toward zero) and contain no rounding logic.

Structure
REQ-026 Shared package fx_fp_pkg SHALL hold EXP_BIAS=127, EXP_W=8, MANT_W=23, FX_W=32, and the FSM state encoding.
REQ-027 One sub-module, fx_norm_shifter, SHALL contain the magnitude shift register and the lz counter (load, shift-enable, msb/lz outputs); the FSM and packing remain in the top module.

Verification (FRAC_W=23 unless stated)
REQ-028 FIXED=0x00800000 (1.0) -> FLOAT=0x3F800000, ACK_FX at edge 11.
REQ-029 FIXED=0xFFA00000 (-0.75) -> FLOAT=0xBF400000, ACK_FX at edge 12.
REQ-030 FIXED=0x00000000 -> FLOAT=0x00000000 at edge 3; FIXED=0x80000000 -> FLOAT=0xC3800000 (-256.0) at edge 3.
REQ-031 FIXED=0x7FFFFFFF -> FLOAT=0x437FFFFF without the macro, 0x43800000 with it, ACK_FX at edge 4.
REQ-032 Begin pulsed during NORM ignored; ACK_FX held 5 cycles until RST_FSM_FX, then IDLE; Begin+RST_FSM_FX together in DONE -> IDLE, no restart.
REQ-033 RST_FF asserted during NORM of 0x00000001 -> next edge IDLE, FLOAT=0, ACK_FX=0, BUSY=0; a following 1.0 conversion completes normally.
